traffic_light_ctrl: RTL

//  Two-road (NS/EW) traffic light sequencer, directly downstream of the 1 Hz tick

---
 rtl/traffic_pkg.sv | 64 ++++++
 rtl/traffic_light_ctrl_phase_timer.sv | 41 ++++
 rtl/traffic_light_ctrl.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// -----------------------------------------------------------------------------
// traffic_pkg
// Shared definitions for the two-road traffic light sequencer:
//   - 3-bit phase encodings (ST_*)
//   - lamp codes {R,Y,G}: LAMP_R, LAMP_Y, LAMP_G
//   - lamps_t: the lamp set driven for one phase
//   - dur():      ticks spent in a phase, given the configured phase lengths
//   - lamp_map(): lamp set for a phase
//   - max3():     helper for sizing the phase counter
// Optional feature macro used by the importers: PED_WALK_EN.
// -----------------------------------------------------------------------------
package traffic_pkg;

    localparam logic [2:0] ST_NS_GREEN     = 3'd0;
    localparam logic [2:0] ST_NS_YELLOW    = 3'd1;
    localparam logic [2:0] ST_EW_GREEN     = 3'd2;
    localparam logic [2:0] ST_EW_YELLOW    = 3'd3;
    localparam logic [2:0] ST_ALL_RED_WALK = 3'd4;

    localparam logic [2:0] LAMP_R = 3'b100;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_G = 3'b001;

    typedef struct packed {
        logic [2:0] ns;
        logic [2:0] ew;
        logic       walk;
    } lamps_t;

    // Length of a phase in ticks. Unknown encodings report 1 so the
    // terminal compare fires at count 0.
    function automatic int unsigned dur(input logic [2:0]  state,
                                        input int unsigned green,
                                        input int unsigned yellow,
                                        input int unsigned walk);
        case (state)
            ST_NS_GREEN,  ST_EW_GREEN:  return green;
            ST_NS_YELLOW, ST_EW_YELLOW: return yellow;
            ST_ALL_RED_WALK:            return walk;
            default:                    return 1;
        endcase
    endfunction

    // Unknown encodings map to the all-red set, which is always safe.
    function automatic lamps_t lamp_map(input logic [2:0] state);
        case (state)
            ST_NS_GREEN:     return '{ns: LAMP_G, ew: LAMP_R, walk: 1'b0};
            ST_NS_YELLOW:    return '{ns: LAMP_Y, ew: LAMP_R, walk: 1'b0};
            ST_EW_GREEN:     return '{ns: LAMP_R, ew: LAMP_G, walk: 1'b0};
            ST_EW_YELLOW:    return '{ns: LAMP_R, ew: LAMP_Y, walk: 1'b0};
            ST_ALL_RED_WALK: return '{ns: LAMP_R, ew: LAMP_R, walk: 1'b1};
            default:         return '{ns: LAMP_R, ew: LAMP_R, walk: 1'b0};
        endcase
    endfunction

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/traffic_light_ctrl_phase_timer.sv
// -----------------------------------------------------------------------------
// phase_timer
// Tick-gated phase counter. It counts tick pulses from 0 up to `last`. The
// tick that arrives while count == last is the terminal tick: count reloads
// to zero on that edge.
// Ports:
//   clk       in   clock
//   rst       in   synchronous active-high reset, count <= 0
//   tick      in   advance strobe
//   clear     in   force count to 0 (used when the phase encoding is bad)
//   last      in   CW  terminal count value, i.e. DUR(phase)-1
//   terminal  out  count has reached `last`; the owner ANDs this with tick
// -----------------------------------------------------------------------------
module phase_timer #(
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tick,
    input  logic          clear,
    input  logic [CW-1:0] last,
    output logic          terminal
);

    logic [CW-1:0] count;

    // In normal operation count never passes `last`, so >= behaves as ==.
    // The >= form also ends a phase whose count somehow ran past its limit.
    assign terminal = (count >= last);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of the order the blocks run in.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (tick) begin
            count <= terminal ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/traffic_light_ctrl.sv
// -----------------------------------------------------------------------------
// traffic_light_ctrl
// Two-road (NS/EW) traffic light sequencer driven by 1 Hz tick pulses.
// Phase order: NS_GREEN -> NS_YELLOW -> EW_GREEN -> EW_YELLOW -> NS_GREEN.
// Phase lengths are counted in ticks, never in clk cycles.
// Optional feature macro: PED_WALK_EN. When it is defined, a pedestrian
// request inserts an ALL_RED_WALK phase after EW_YELLOW.
// Ports:
//   clk         in   clock
//   rst         in   synchronous active-high reset
//   tick        in   1-cycle advance strobe
//   ped_req     in   pedestrian request, pulse or level
//   ns_light    out  3  NS lamps {R,Y,G}, one-hot, registered
//   ew_light    out  3  EW lamps {R,Y,G}, one-hot, registered
//   walk        out  pedestrian walk lamp, registered (tied 0 without macro)
//   phase_done  out  1-cycle pulse on each phase transition
// -----------------------------------------------------------------------------
module traffic_light_ctrl
    import traffic_pkg::*;
#(
    parameter int GREEN_TICKS  = 5,
    parameter int YELLOW_TICKS = 2,
    parameter int WALK_TICKS   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       ped_req,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic       walk,
    output logic       phase_done
);

    localparam int unsigned MAX_TICKS = max3(GREEN_TICKS, YELLOW_TICKS, WALK_TICKS);
    localparam int          CW        = $clog2(MAX_TICKS + 1);

    logic [2:0]    state;
    logic [2:0]    state_next;
    logic [CW-1:0] last;
    logic          terminal;
    logic          illegal;
    logic          advance;
    logic          ped_hit;
    lamps_t        lamps_next;

    // Without the walk feature, ALL_RED_WALK counts as an illegal encoding.
`ifdef PED_WALK_EN
    assign illegal = (state > ST_ALL_RED_WALK);
`else
    assign illegal = (state > ST_EW_YELLOW);
`endif

    assign last    = CW'(dur(state, GREEN_TICKS, YELLOW_TICKS, WALK_TICKS) - 1);
    assign advance = tick & terminal & ~illegal;

    phase_timer #(
        .CW (CW)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .clear    (illegal),
        .last     (last),
        .terminal (terminal)
    );

`ifdef PED_WALK_EN
    logic ped_pending;
`endif

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        state_next = state;
        ped_hit    = 1'b0;
        if (illegal) begin
            state_next = ST_NS_GREEN;
        end else if (advance) begin
            case (state)
                ST_NS_GREEN:  state_next = ST_NS_YELLOW;
                ST_NS_YELLOW: state_next = ST_EW_GREEN;
                ST_EW_GREEN:  state_next = ST_EW_YELLOW;
                ST_EW_YELLOW: begin
`ifdef PED_WALK_EN
                    // A request arriving in this very cycle still counts.
                    if (ped_pending || ped_req) begin
                        state_next = ST_ALL_RED_WALK;
                        ped_hit    = 1'b1;
                    end else begin
                        state_next = ST_NS_GREEN;
                    end
`else
                    state_next = ST_NS_GREEN;
`endif
                end
                default:      state_next = ST_NS_GREEN;
            endcase
        end
    end

    assign lamps_next = lamp_map(state_next);

    // Lamps are registered from the next state. They switch on the same edge
    // as the phase and never pass through a combinational decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_NS_GREEN;
            ns_light   <= LAMP_G;
            ew_light   <= LAMP_R;
            phase_done <= 1'b0;
        end else begin
            state      <= state_next;
            ns_light   <= lamps_next.ns;
            ew_light   <= lamps_next.ew;
            phase_done <= advance;
        end
    end

`ifdef PED_WALK_EN
    // The sticky request is consumed by the EW_YELLOW -> walk transition.
    // A request during the walk phase arms it again for the next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            ped_pending <= 1'b0;
            walk        <= 1'b0;
        end else begin
            walk <= lamps_next.walk;
            if (ped_hit) begin
                ped_pending <= 1'b0;
            end else if (ped_req) begin
                ped_pending <= 1'b1;
            end
        end
    end
`else
    logic unused_ped;
    assign unused_ped = ^{ped_req, ped_hit, lamps_next.walk};
    assign walk       = 1'b0;
`endif

endmodule
